// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos EX->WB pipe and write-back stage.
package kronos_types;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic [3:0] LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] STORE_ADDR_MISALIGNED = 4'd6;

  typedef enum logic {STEADY, LSU} wb_state_e;

  typedef struct packed {
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [1:0]  data_size;
    logic        data_uns;
    logic        except;
    logic [3:0]  excause;
  } pipeEXWB_t;

endpackage

// File: rtl/kronos_lsu_align.sv
// Combinational byte-lane steering for the data bus: store replication,
// byte enables, load extraction/extension and misalignment detection.
module kronos_lsu_align
  import kronos_types::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  mask,
  output logic        misaligned
);

  logic [7:0]  b;
  logic [15:0] h;

  // Steer lanes by access size; anything other than byte/half acts as a word.
  always_comb begin
    misaligned = 1'b0;
    mask       = 4'b1111;
    store_data = sdata;
    load_data  = rdata;
    b          = rdata[{addr, 3'b000} +: 8];
    h          = rdata[{addr[1], 4'b0000} +: 16];
    case (size)
      BYTE: begin
        store_data = {4{sdata[7:0]}};
        mask       = 4'b0001 << addr;
        load_data  = {{24{~uns & b[7]}}, b};
      end
      HALF: begin
        misaligned = addr[0];
        store_data = {2{sdata[15:0]}};
        mask       = 4'b0011 << addr;
        load_data  = {{16{~uns & h[15]}}, h};
      end
      default: misaligned = (addr != 2'b00);
    endcase
  end

endmodule

// File: rtl/kronos_wb.sv
// Kronos write-back stage: register writes, branch redirects, traps and
// the load/store bus transaction. Only accepts new entries in STEADY.
module kronos_wb
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic        branch_vld,
  output logic [31:0] branch_target,
  output logic        trap_vld,
  output logic [3:0]  trap_cause,
  output logic [31:0] data_addr,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_mask,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_ack
);

  wb_state_e   state;

  // Access context kept for the duration of an outstanding load/store.
  logic [1:0]  lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_uns;
  logic        lsu_ld;
  logic        lsu_rdw;
  logic [4:0]  lsu_rd;

  logic [1:0]  al_addr;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [31:0] al_load;
  logic [31:0] al_store;
  logic [3:0]  al_mask;
  logic        al_mis;

  logic        is_mem;
  logic        do_branch;

  assign pipe_in_rdy = (state == STEADY);
  assign is_mem      = execute.ld | execute.st;
  assign do_branch   = execute.branch | (execute.branch_cond & execute.result1[0]);

  // Aligner sees the incoming entry in STEADY and the latched access in LSU.
  assign al_addr = (state == LSU) ? lsu_addr : execute.result1[1:0];
  assign al_size = (state == LSU) ? lsu_size : execute.data_size;
  assign al_uns  = (state == LSU) ? lsu_uns  : execute.data_uns;

  kronos_lsu_align u_align (
    .addr       (al_addr),
    .size       (al_size),
    .uns        (al_uns),
    .rdata      (data_rdata),
    .sdata      (execute.result2),
    .load_data  (al_load),
    .store_data (al_store),
    .mask       (al_mask),
    .misaligned (al_mis)
  );

  // Write-back FSM; pulses default low and the bus request is held until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= STEADY;
      regwr_en      <= 1'b0;
      regwr_sel     <= '0;
      regwr_data    <= '0;
      branch_vld    <= 1'b0;
      branch_target <= '0;
      trap_vld      <= 1'b0;
      trap_cause    <= '0;
      data_addr     <= '0;
      data_req      <= 1'b0;
      data_wr       <= 1'b0;
      data_mask     <= '0;
      data_wdata    <= '0;
      lsu_addr      <= '0;
      lsu_size      <= '0;
      lsu_uns       <= 1'b0;
      lsu_ld        <= 1'b0;
      lsu_rdw       <= 1'b0;
      lsu_rd        <= '0;
    end else begin
      regwr_en   <= 1'b0;
      branch_vld <= 1'b0;
      trap_vld   <= 1'b0;
      case (state)
        STEADY: begin
          if (pipe_in_vld) begin
            if (execute.except) begin
              trap_vld   <= 1'b1;
              trap_cause <= execute.excause;
            end else if (is_mem && al_mis) begin
              trap_vld   <= 1'b1;
              trap_cause <= execute.ld ? LOAD_ADDR_MISALIGNED : STORE_ADDR_MISALIGNED;
            end else if (is_mem) begin
              state      <= LSU;
              data_req   <= 1'b1;
              data_addr  <= {execute.result1[31:2], 2'b00};
              data_wr    <= execute.st;
              data_mask  <= execute.st ? al_mask : 4'b1111;
              data_wdata <= al_store;
              lsu_addr   <= execute.result1[1:0];
              lsu_size   <= execute.data_size;
              lsu_uns    <= execute.data_uns;
              lsu_ld     <= execute.ld;
              lsu_rdw    <= execute.rd_write;
              lsu_rd     <= execute.rd;
            end else begin
              if (execute.rd_write && execute.rd != 5'd0) begin
                regwr_en   <= 1'b1;
                regwr_sel  <= execute.rd;
                regwr_data <= execute.result1;
              end
              if (do_branch) begin
                branch_vld    <= 1'b1;
                branch_target <= execute.result2;
              end
            end
          end
        end
        LSU: begin
          if (data_ack) begin
            state    <= STEADY;
            data_req <= 1'b0;
            if (lsu_ld && lsu_rdw && lsu_rd != 5'd0) begin
              regwr_en   <= 1'b1;
              regwr_sel  <= lsu_rd;
              regwr_data <= al_load;
            end
          end
        end
        default: state <= STEADY;
      endcase
    end
  end

endmodule

// File: tb/tb_kronos_wb.sv
// Directed bench for the Kronos write-back stage.
module tb_kronos_wb;
  import kronos_types::*;

  logic        clk = 1'b0;
  logic        rst;
  pipeEXWB_t   execute;
  logic        pipe_in_vld;
  logic        pipe_in_rdy;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic        branch_vld;
  logic [31:0] branch_target;
  logic        trap_vld;
  logic [3:0]  trap_cause;
  logic [31:0] data_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_mask;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;

  int errors = 0;
  int checks = 0;

  kronos_wb dut (
    .clk           (clk),
    .rst           (rst),
    .execute       (execute),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_rdy   (pipe_in_rdy),
    .regwr_en      (regwr_en),
    .regwr_sel     (regwr_sel),
    .regwr_data    (regwr_data),
    .branch_vld    (branch_vld),
    .branch_target (branch_target),
    .trap_vld      (trap_vld),
    .trap_cause    (trap_cause),
    .data_addr     (data_addr),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_mask     (data_mask),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_ack      (data_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for exactly one accept edge.
  task automatic send(input pipeEXWB_t e);
    execute     = e;
    pipe_in_vld = 1'b1;
    tick();
    pipe_in_vld = 1'b0;
    execute     = '0;
  endtask

  pipeEXWB_t e;

  initial begin
    rst         = 1'b1;
    execute     = '0;
    pipe_in_vld = 1'b0;
    data_rdata  = '0;
    data_ack    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_regwr_en", 32'(regwr_en), 32'd0);
    chk("rst_branch_vld", 32'(branch_vld), 32'd0);
    chk("rst_trap_vld", 32'(trap_vld), 32'd0);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_data_mask", 32'(data_mask), 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_regwr_data", regwr_data, 32'd0);
    chk("rst_rdy", 32'(pipe_in_rdy), 32'd1);

    // ALU write
    e = '0; e.result1 = 32'hDEADBEEF; e.rd = 5'd5; e.rd_write = 1'b1;
    send(e);
    chk("alu_en", 32'(regwr_en), 32'd1);
    chk("alu_sel", 32'(regwr_sel), 32'd5);
    chk("alu_data", regwr_data, 32'hDEADBEEF);
    chk("alu_branch", 32'(branch_vld), 32'd0);
    tick();
    chk("alu_pulse_end", 32'(regwr_en), 32'd0);
    e.rd = 5'd0;
    send(e);
    chk("alu_rd0_en", 32'(regwr_en), 32'd0);

    // Conditional branch taken / not taken, then JAL
    e = '0; e.branch_cond = 1'b1; e.result1 = 32'd1; e.result2 = 32'h100;
    send(e);
    chk("bc_vld", 32'(branch_vld), 32'd1);
    chk("bc_target", branch_target, 32'h100);
    chk("bc_no_wr", 32'(regwr_en), 32'd0);
    e.result1 = 32'd0;
    send(e);
    chk("bc_nt_vld", 32'(branch_vld), 32'd0);
    e = '0; e.branch = 1'b1; e.rd = 5'd1; e.rd_write = 1'b1;
    e.result1 = 32'h24; e.result2 = 32'h80;
    send(e);
    chk("jal_wr", 32'(regwr_en), 32'd1);
    chk("jal_data", regwr_data, 32'h24);
    chk("jal_sel", 32'(regwr_sel), 32'd1);
    chk("jal_br", 32'(branch_vld), 32'd1);
    chk("jal_target", branch_target, 32'h80);

    // Signed byte load, ack after 3 wait cycles
    e = '0; e.ld = 1'b1; e.result1 = 32'h1003; e.data_size = BYTE;
    e.rd = 5'd7; e.rd_write = 1'b1;
    send(e);
    chk("lb_req", 32'(data_req), 32'd1);
    chk("lb_addr", data_addr, 32'h1000);
    chk("lb_mask", 32'(data_mask), 32'hF);
    chk("lb_wr", 32'(data_wr), 32'd0);
    chk("lb_rdy0", 32'(pipe_in_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lb_wait_req", 32'(data_req), 32'd1);
      chk("lb_wait_rdy", 32'(pipe_in_rdy), 32'd0);
      chk("lb_wait_nowr", 32'(regwr_en), 32'd0);
    end
    data_ack = 1'b1; data_rdata = 32'h80FFFFFF;
    tick();
    data_ack = 1'b0;
    chk("lb_wr_en", 32'(regwr_en), 32'd1);
    chk("lb_sel", 32'(regwr_sel), 32'd7);
    chk("lb_data", regwr_data, 32'hFFFFFF80);
    chk("lb_req_drop", 32'(data_req), 32'd0);
    chk("lb_rdy1", 32'(pipe_in_rdy), 32'd1);

    // Unsigned byte load with same-cycle ack
    e.data_uns = 1'b1;
    send(e);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("lbu_data", regwr_data, 32'h00000080);
    chk("lbu_en", 32'(regwr_en), 32'd1);
    chk("lbu_rdy", 32'(pipe_in_rdy), 32'd1);

    // Half store
    e = '0; e.st = 1'b1; e.result1 = 32'h2002; e.result2 = 32'h1234ABCD;
    e.data_size = HALF; e.rd = 5'd9;
    send(e);
    chk("sh_addr", data_addr, 32'h2000);
    chk("sh_mask", 32'(data_mask), 32'hC);
    chk("sh_wdata", data_wdata, 32'hABCDABCD);
    chk("sh_wr", 32'(data_wr), 32'd1);
    chk("sh_req", 32'(data_req), 32'd1);
    tick();
    chk("sh_hold_wdata", data_wdata, 32'hABCDABCD);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("sh_no_wr", 32'(regwr_en), 32'd0);
    chk("sh_req_drop", 32'(data_req), 32'd0);

    // Misaligned accesses and forwarded exception
    e = '0; e.ld = 1'b1; e.result1 = 32'h3001; e.data_size = WORD;
    e.rd = 5'd3; e.rd_write = 1'b1;
    send(e);
    chk("mis_lw_trap", 32'(trap_vld), 32'd1);
    chk("mis_lw_cause", 32'(trap_cause), 32'd4);
    chk("mis_lw_req", 32'(data_req), 32'd0);
    chk("mis_lw_nowr", 32'(regwr_en), 32'd0);
    e = '0; e.st = 1'b1; e.result1 = 32'h4001; e.data_size = HALF;
    send(e);
    chk("mis_sh_cause", 32'(trap_cause), 32'd6);
    chk("mis_sh_req", 32'(data_req), 32'd0);
    e = '0; e.except = 1'b1; e.excause = 4'd2; e.rd = 5'd3; e.rd_write = 1'b1;
    e.branch = 1'b1;
    send(e);
    chk("exc_trap", 32'(trap_vld), 32'd1);
    chk("exc_cause", 32'(trap_cause), 32'd2);
    chk("exc_nowr", 32'(regwr_en), 32'd0);
    chk("exc_nobr", 32'(branch_vld), 32'd0);
    tick();
    chk("exc_pulse_end", 32'(trap_vld), 32'd0);

    // Reset in the middle of an outstanding load
    e = '0; e.ld = 1'b1; e.result1 = 32'h5000; e.data_size = WORD;
    e.rd = 5'd4; e.rd_write = 1'b1;
    send(e);
    chk("rl_req", 32'(data_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rl_req_drop", 32'(data_req), 32'd0);
    chk("rl_nowr", 32'(regwr_en), 32'd0);
    chk("rl_rdy", 32'(pipe_in_rdy), 32'd1);
    data_ack = 1'b1; data_rdata = 32'h12345678;
    tick();
    data_ack = 1'b0;
    chk("rl_late_ack_nowr", 32'(regwr_en), 32'd0);
    chk("rl_late_ack_req", 32'(data_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
